// File: rtl/kl8e_ctl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// kl8e_ctl : KL8E console controller - IOT decode, kbd/tty flags, UART FSMs
// Revision : 1.0
// ----------------------------------------------------------------------------
module kl8e_ctl #(
    parameter logic [5:0] KBD_DEV = 6'o03,
    parameter logic [5:0] TTY_DEV = 6'o04
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iot,
    input  logic [5:0] io_select,
    input  logic [2:0] io_op,
    input  logic [7:0] io_ac,
    output logic [7:0] io_data_out,
    output logic       io_load_ac,
    output logic       io_clear_ac,
    output logic       io_skip,
    output logic       io_interrupt,
    output logic       tx_overrun,
    output logic       tx_req,
    input  logic       tx_ack,
    output logic [7:0] tx_data,
    input  logic       tx_empty,
    output logic       rx_req,
    input  logic       rx_ack,
    input  logic       rx_empty,
    input  logic [7:0] rx_data
);

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_REQ   = 2'd1;
    localparam logic [1:0] TX_GUARD = 2'd2;
    localparam logic [1:0] TX_BUSY  = 2'd3;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_REQ   = 2'd1;
    localparam logic [1:0] RX_CAPT  = 2'd2;
    localparam logic [1:0] RX_FULL  = 2'd3;

    logic [1:0] r_tx_state;
    logic [1:0] r_rx_state;
    logic       r_kbd_flag;
    logic       r_tty_flag;
    logic [7:0] r_kbd_buf;
    logic [7:0] r_tx_data;
    logic       r_overrun;

    logic w_kbd_sel;
    logic w_tty_sel;
    logic w_kbd_clr;
    logic w_tty_set;
    logic w_tty_clr;
    logic w_print;
    logic w_tx_done;
    logic w_rx_capt;

    // Op 0 has its own meaning on each device; other ops combine their bits.
    assign w_kbd_sel = iot && (io_select == KBD_DEV);
    assign w_tty_sel = iot && (io_select == TTY_DEV);
    assign w_kbd_clr = w_kbd_sel && ((io_op == 3'd0) || io_op[1]);
    assign w_tty_set = w_tty_sel && (io_op == 3'd0);
    assign w_tty_clr = w_tty_sel && io_op[1];
    assign w_print   = w_tty_sel && io_op[2];
    assign w_tx_done = (r_tx_state == TX_BUSY) && tx_empty;
    assign w_rx_capt = (r_rx_state == RX_CAPT);

    assign io_skip      = (w_kbd_sel && io_op[0] && r_kbd_flag) ||
                          (w_tty_sel && io_op[0] && r_tty_flag);
    assign io_clear_ac  = w_kbd_sel && io_op[1];
    assign io_load_ac   = w_kbd_sel && io_op[2];
    assign io_data_out  = r_kbd_buf;
    assign io_interrupt = r_kbd_flag || r_tty_flag;
    assign tx_overrun   = r_overrun;
    assign tx_data      = r_tx_data;
    assign tx_req       = (r_tx_state == TX_REQ);
    assign rx_req       = (r_rx_state == RX_REQ);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_data  <= 8'd0;
            r_overrun  <= 1'b0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_print) begin
                        r_tx_data  <= io_ac;
                        r_tx_state <= TX_REQ;
                    end
                end
                TX_REQ:   if (tx_ack) r_tx_state <= TX_GUARD;
                TX_GUARD: r_tx_state <= TX_BUSY;
                TX_BUSY:  if (tx_empty) r_tx_state <= TX_IDLE;
                default:  r_tx_state <= TX_IDLE;
            endcase
            if (w_print && (r_tx_state != TX_IDLE)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state <= RX_IDLE;
            r_kbd_buf  <= 8'd0;
        end else begin
            case (r_rx_state)
                RX_IDLE: if (!rx_empty && !r_kbd_flag) r_rx_state <= RX_REQ;
                RX_REQ:  if (rx_ack) r_rx_state <= RX_CAPT;
                RX_CAPT: begin
                    r_kbd_buf  <= rx_data;
                    r_rx_state <= RX_FULL;
                end
                RX_FULL: if (!r_kbd_flag) r_rx_state <= RX_IDLE;
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // Hardware set takes priority over a same-cycle IOT clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_kbd_flag <= 1'b0;
            r_tty_flag <= 1'b0;
        end else begin
            if (w_rx_capt) begin
                r_kbd_flag <= 1'b1;
            end else if (w_kbd_clr) begin
                r_kbd_flag <= 1'b0;
            end
            if (w_tx_done || w_tty_set) begin
                r_tty_flag <= 1'b1;
            end else if (w_tty_clr) begin
                r_tty_flag <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kl8e_ctl.sv
`default_nettype none
// Bench for kl8e_ctl: decode vector table, UART handshake sequences, tx/rx scoreboards.
module tb_kl8e_ctl;

    localparam logic [5:0] KBD = 6'o03;
    localparam logic [5:0] TTY = 6'o04;

    logic       clk = 1'b0;
    logic       reset, iot;
    logic [5:0] io_select;
    logic [2:0] io_op;
    logic [7:0] io_ac, io_data_out, tx_data, rx_data;
    logic       io_load_ac, io_clear_ac, io_skip, io_interrupt, tx_overrun;
    logic       tx_req, tx_ack, tx_empty, rx_req, rx_ack, rx_empty;

    int checks = 0;
    int failures = 0;
    int tx_pulses = 0;
    int rx_pulses = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic       s_skip, s_clr, s_load;
    logic [7:0] s_data;

    typedef struct {
        logic       iot;
        logic [5:0] sel;
        logic [2:0] op;
        logic       skip;
        logic       clr;
        logic       load;
        logic       irq;
    } vec_t;
    vec_t tbl[14];

    always #5 clk = ~clk;

    kl8e_ctl dut (
        .clk(clk), .reset(reset), .iot(iot), .io_select(io_select), .io_op(io_op),
        .io_ac(io_ac), .io_data_out(io_data_out), .io_load_ac(io_load_ac),
        .io_clear_ac(io_clear_ac), .io_skip(io_skip), .io_interrupt(io_interrupt),
        .tx_overrun(tx_overrun), .tx_req(tx_req), .tx_ack(tx_ack), .tx_data(tx_data),
        .tx_empty(tx_empty), .rx_req(rx_req), .rx_ack(rx_ack), .rx_empty(rx_empty),
        .rx_data(rx_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic iot_drive(input logic en, input logic [5:0] sel, input logic [2:0] op,
                             input logic [7:0] ac);
        iot = en; io_select = sel; io_op = op; io_ac = ac;
        #1;
        s_skip = io_skip; s_clr = io_clear_ac; s_load = io_load_ac; s_data = io_data_out;
    endtask

    task automatic iot_end();
        step();
        iot = 1'b0; io_select = 6'd0; io_op = 3'd0;
    endtask

    task automatic do_iot(input logic [5:0] sel, input logic [2:0] op, input logic [7:0] ac);
        iot_drive(1'b1, sel, op, ac);
        iot_end();
    endtask

    // UART transmitter: acks one cycle after req, then stays busy.
    task automatic serve_tx(input int busy, input int mid_ac, input logic [7:0] exp_data,
                            input logic tcf_end);
        int n = 0;
        while (!tx_req && n < 10) begin step(); n++; end
        chk("tx_req_seen", tx_req, 1);
        step(); tx_ack = 1'b1; #1;
        chk("tx_req_held", tx_req, 1);
        step(); tx_ack = 1'b0; tx_empty = 1'b0; #1;
        chk("tx_req_drop_guard", tx_req, 0);
        for (int i = 0; i < busy; i++) begin
            step();
            if (mid_ac >= 0 && i == busy / 2) begin
                do_iot(TTY, 3'd4, mid_ac[7:0]);
                #1;
                chk("overrun_set", tx_overrun, 1);
                chk("overrun_tx_data_kept", tx_data, exp_data);
                chk("overrun_no_req", tx_req, 0);
            end
        end
        chk("tty_flag_clear_while_busy", io_interrupt, 0);
        step(); tx_empty = 1'b1;
        if (tcf_end) do_iot(TTY, 3'd2, 8'd0);
        else step();
        #1;
        chk("tty_flag_after_done", io_interrupt, 1);
    endtask

    // UART receiver: acks one cycle after req, data valid the cycle after ack.
    task automatic serve_rx(input logic [7:0] c, input logic krb_capt, input logic [7:0] old,
                            input logic last);
        int n = 0;
        while (!rx_req && n < 10) begin step(); n++; end
        chk("rx_req_seen", rx_req, 1);
        step(); rx_ack = 1'b1;
        step(); rx_ack = 1'b0; rx_data = c;
        if (last) rx_empty = 1'b1;
        #1;
        chk("rx_req_drop_capt", rx_req, 0);
        if (krb_capt) begin
            iot_drive(1'b1, KBD, 3'd6, 8'd0);
            chk("krb_capt_old_buf", s_data, old);
            iot_end();
        end else begin
            step();
        end
        rx_data = 8'h00;
        #1;
        chk("kbd_flag_set", io_interrupt, 1);
    endtask

    task automatic krb_check();
        logic [7:0] e;
        iot_drive(1'b1, KBD, 3'd6, 8'd0);
        chk("krb_clear_ac", s_clr, 1);
        chk("krb_load_ac", s_load, 1);
        if (rx_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL krb_sb: got %0h with no character expected", s_data);
        end else begin
            e = rx_q.pop_front();
            chk("krb_data", s_data, e);
        end
        iot_end();
    endtask

    // Scoreboard monitor: every new tx_req must carry the next queued character.
    initial begin
        logic prev_tx, prev_rx;
        logic [7:0] e;
        prev_tx = 1'b0; prev_rx = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (tx_req && !prev_tx) begin
                tx_pulses++;
                if (tx_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL tx_sb: got req with data %0h, none expected", tx_data);
                end else begin
                    e = tx_q.pop_front();
                    chk("tx_sb_data", tx_data, e);
                end
            end
            if (rx_req && !prev_rx) rx_pulses++;
            prev_tx = tx_req;
            prev_rx = rx_req;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{1'b1, TTY,    3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, KBD,    3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, KBD,    3'd2, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, KBD,    3'd4, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, KBD,    3'd6, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, KBD,    3'd3, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 6'o05,  3'd7, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, TTY,    3'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, TTY,    3'd1, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, TTY,    3'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, KBD,    3'd1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{1'b1, TTY,    3'd3, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, TTY,    3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, TTY,    3'd2, 1'b0, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; iot = 1'b0; io_select = 6'd0; io_op = 3'd0; io_ac = 8'd0;
        tx_ack = 1'b0; tx_empty = 1'b1; rx_ack = 1'b0; rx_empty = 1'b1; rx_data = 8'd0;
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk("rst_tx_req", tx_req, 0);
        chk("rst_rx_req", rx_req, 0);
        chk("rst_irq", io_interrupt, 0);
        chk("rst_overrun", tx_overrun, 0);
        chk("rst_tx_data", tx_data, 0);
        repeat (10) step();
        chk("idle_tx_req", tx_req, 0);
        chk("idle_rx_req", rx_req, 0);

        for (int i = 0; i < 14; i++) begin
            iot_drive(tbl[i].iot, tbl[i].sel, tbl[i].op, 8'd0);
            chk($sformatf("vec%0d_skip", i), s_skip, tbl[i].skip);
            chk($sformatf("vec%0d_clear_ac", i), s_clr, tbl[i].clr);
            chk($sformatf("vec%0d_load_ac", i), s_load, tbl[i].load);
            if (tbl[i].load) chk($sformatf("vec%0d_data", i), s_data, 0);
            iot_end();
            chk($sformatf("vec%0d_irq", i), io_interrupt, tbl[i].irq);
        end

        // TLS, long transmit
        tx_q.push_back(8'o101);
        do_iot(TTY, 3'd6, 8'o101);
        chk("tls_req_next_cycle", tx_req, 1);
        serve_tx(38, -1, 8'o101, 1'b0);
        chk("tls_tx_data", tx_data, 8'o101);
        chk("tls_one_pulse", tx_pulses, 1);
        chk("tls_no_overrun", tx_overrun, 0);
        iot_drive(1'b1, TTY, 3'd1, 8'd0);
        chk("tsf_skip_after_print", s_skip, 1);
        iot_end();
        do_iot(TTY, 3'd2, 8'd0);
        chk("tcf_clears", io_interrupt, 0);

        // keyboard: UART holds "A","B"
        rx_q.push_back(8'o101);
        rx_q.push_back(8'o102);
        rx_empty = 1'b0;
        step();
        chk("rx_req_next_cycle", rx_req, 1);
        serve_rx(8'o101, 1'b0, 8'd0, 1'b0);
        repeat (6) step();
        chk("rx_single_req_while_full", rx_pulses, 1);
        krb_check();
        serve_rx(8'o102, 1'b1, 8'o101, 1'b1);
        step();
        chk("krb_capt_flag_kept", io_interrupt, 1);
        krb_check();
        chk("rx_two_reqs", rx_pulses, 2);

        // TPC during TX_BUSY, completion coinciding with TCF
        tx_q.push_back(8'o125);
        do_iot(TTY, 3'd4, 8'o125);
        serve_tx(6, 8'o177, 8'o125, 1'b1);
        chk("overrun_one_pulse", tx_pulses, 2);
        chk("overrun_sticky", tx_overrun, 1);
        do_iot(TTY, 3'd2, 8'd0);

        // reset while both handshakes are requesting
        do_iot(TTY, 3'd0, 8'd0);
        rx_empty = 1'b0;
        tx_q.push_back(8'o033);
        do_iot(TTY, 3'd4, 8'o033);
        chk("pre_rst_tx_req", tx_req, 1);
        chk("pre_rst_rx_req", rx_req, 1);
        reset = 1'b1; rx_empty = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_tx_req", tx_req, 0);
        chk("mid_rst_rx_req", rx_req, 0);
        chk("mid_rst_irq", io_interrupt, 0);
        chk("mid_rst_overrun", tx_overrun, 0);
        chk("mid_rst_tx_data", tx_data, 0);
        chk("mid_rst_buf", io_data_out, 0);
        repeat (8) step();
        chk("post_rst_no_tx", tx_pulses, 3);
        chk("post_rst_no_rx", rx_pulses, 3);

        tx_q.push_back(8'o044);
        do_iot(TTY, 3'd4, 8'o044);
        serve_tx(3, -1, 8'o044, 1'b0);
        chk("recover_pulses", tx_pulses, 4);
        chk("recover_tx_data", tx_data, 8'o044);
        chk("tx_q_drained", tx_q.size(), 0);
        chk("rx_q_drained", rx_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
